// File: rtl/count_cmd_gen.sv
// Counter command front end: synchronize and debounce buttons,
// auto-repeat Up/Dw, one-shot LD with switch capture.

module count_cmd_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

module count_cmd_db #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync,
   output logic db
);

   localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (sync != db) begin
         if (cnt == DB_LAST) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

module count_cmd_rep #(
   parameter int HOLD_CYCLES = 8,
   parameter int REP_CYCLES  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic db,
   output logic req
);

   localparam int MAXC = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } st_t;

   st_t           st;
   logic [TW-1:0] tmr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= IDLE;
         tmr <= '0;
      end else begin
         unique case (st)
            IDLE: begin
               if (db) begin
                  st  <= HOLD;
                  tmr <= '0;
               end
            end
            HOLD: begin
               if (!db) begin
                  st <= IDLE;
               end else if (tmr == HOLD_LAST) begin
                  st  <= REPEAT;
                  tmr <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            REPEAT: begin
               if (!db) begin
                  st <= IDLE;
               end else if (tmr == REP_LAST) begin
                  tmr <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   // IDLE with db high can only follow a rising edge of db
   always_comb begin
      req = 1'b0;
      unique case (1'b1)
         (st == IDLE):   req = db;
         (st == HOLD):   req = db && (tmr == HOLD_LAST);
         (st == REPEAT): req = db && (tmr == REP_LAST);
         default:        req = 1'b0;
      endcase
   end

endmodule

module count_cmd_gen #(
   parameter int DB_CYCLES   = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int REP_CYCLES  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btnU,
   input  logic        btnD,
   input  logic        btnL,
   input  logic [15:0] sw,
   output logic        Up,
   output logic        Dw,
   output logic        LD,
   output logic [15:0] Din
);

   logic syn_u, syn_d, syn_l;
   logic db_u, db_d, db_l;
   logic db_l_q;
   logic req_u, req_d, req_l;

   count_cmd_sync u_sync_u (.clk(clk), .rst_n(rst_n), .d(btnU), .q(syn_u));
   count_cmd_sync u_sync_d (.clk(clk), .rst_n(rst_n), .d(btnD), .q(syn_d));
   count_cmd_sync u_sync_l (.clk(clk), .rst_n(rst_n), .d(btnL), .q(syn_l));

   count_cmd_db #(.DB_CYCLES(DB_CYCLES)) u_db_u (
      .clk(clk), .rst_n(rst_n), .sync(syn_u), .db(db_u)
   );
   count_cmd_db #(.DB_CYCLES(DB_CYCLES)) u_db_d (
      .clk(clk), .rst_n(rst_n), .sync(syn_d), .db(db_d)
   );
   count_cmd_db #(.DB_CYCLES(DB_CYCLES)) u_db_l (
      .clk(clk), .rst_n(rst_n), .sync(syn_l), .db(db_l)
   );

   count_cmd_rep #(.HOLD_CYCLES(HOLD_CYCLES), .REP_CYCLES(REP_CYCLES)) u_rep_u (
      .clk(clk), .rst_n(rst_n), .db(db_u), .req(req_u)
   );
   count_cmd_rep #(.HOLD_CYCLES(HOLD_CYCLES), .REP_CYCLES(REP_CYCLES)) u_rep_d (
      .clk(clk), .rst_n(rst_n), .db(db_d), .req(req_d)
   );

   assign req_l = db_l & ~db_l_q;

   // Up/Dw lose to LD and to the opposite held button; losers are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_l_q <= 1'b0;
         Up     <= 1'b0;
         Dw     <= 1'b0;
         LD     <= 1'b0;
         Din    <= '0;
      end else begin
         db_l_q <= db_l;
         Up     <= req_u & ~req_l & ~db_d;
         Dw     <= req_d & ~req_l & ~db_u;
         LD     <= req_l;
         if (req_l) Din <= sw;
      end
   end

endmodule

// File: tb/tb_count_cmd_gen.sv
// Directed bench for count_cmd_gen with default parameters
// (DB_CYCLES=4, HOLD_CYCLES=8, REP_CYCLES=3).

module tb_count_cmd_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btnU = 1'b0;
   logic        btnD = 1'b0;
   logic        btnL = 1'b0;
   logic [15:0] sw = 16'h0000;
   logic        Up, Dw, LD;
   logic [15:0] Din;

   int checks = 0;
   int errors = 0;

   count_cmd_gen dut (
      .clk(clk), .rst_n(rst_n),
      .btnU(btnU), .btnD(btnD), .btnL(btnL), .sw(sw),
      .Up(Up), .Dw(Dw), .LD(LD), .Din(Din)
   );

   always #5 clk = ~clk;

   task automatic idle(input int n);
      btnU = 1'b0;
      btnD = 1'b0;
      btnL = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({Up, Dw, LD} !== 3'b000 || Din !== 16'h0000) begin
         errors++;
         $display("FAIL reset_hold got %b%b%b din=%h want 000 din=0000",
                  Up, Dw, LD, Din);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 50; e++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({Up, Dw, LD} !== 3'b000 || Din !== 16'h0000) begin
            errors++;
            $display("FAIL reset_idle e=%0d got %b%b%b din=%h want 000 din=0000",
                     e, Up, Dw, LD, Din);
         end
      end
   endtask

   task automatic test_clean_press;
      logic exp;
      btnU = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         if (e == 5) btnU = 1'b0;
         exp = (e == 7);
         checks++;
         if (Up !== exp || Dw !== 1'b0 || LD !== 1'b0) begin
            errors++;
            $display("FAIL clean_press e=%0d got up=%b dw=%b ld=%b want up=%b dw=0 ld=0",
                     e, Up, Dw, LD, exp);
         end
      end
   endtask

   task automatic test_bounce;
      logic exp;
      btnD = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         btnD = (e == 2);
         checks++;
         if (Dw !== 1'b0 || Up !== 1'b0 || LD !== 1'b0) begin
            errors++;
            $display("FAIL bounce_reject e=%0d got up=%b dw=%b ld=%b want 000",
                     e, Up, Dw, LD);
         end
      end
      idle(10);
      btnD = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         btnD = (e == 1) || (e >= 5 && e <= 12);
         exp = (e == 12);
         checks++;
         if (Dw !== exp || Up !== 1'b0 || LD !== 1'b0) begin
            errors++;
            $display("FAIL glitch_press e=%0d got dw=%b up=%b ld=%b want dw=%b up=0 ld=0",
                     e, Dw, Up, LD, exp);
         end
      end
   endtask

   task automatic test_auto_repeat;
      logic exp;
      btnU = 1'b1;
      for (int e = 1; e <= 50; e++) begin
         @(posedge clk);
         #1;
         if (e == 28) btnU = 1'b0;
         exp = (e == 7) || (e >= 15 && e <= 33 && (e - 15) % 3 == 0);
         checks++;
         if (Up !== exp || Dw !== 1'b0 || LD !== 1'b0) begin
            errors++;
            $display("FAIL auto_repeat e=%0d got up=%b dw=%b ld=%b want up=%b dw=0 ld=0",
                     e, Up, Dw, LD, exp);
         end
      end
   endtask

   task automatic test_load;
      logic        exp;
      logic [15:0] dexp;
      sw   = 16'hA5C3;
      btnL = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         if (e == 10) sw = 16'h1234;
         if (e == 20) btnL = 1'b0;
         exp  = (e == 7);
         dexp = (e >= 7) ? 16'hA5C3 : 16'h0000;
         checks++;
         if (LD !== exp || Din !== dexp || Up !== 1'b0 || Dw !== 1'b0) begin
            errors++;
            $display("FAIL load e=%0d got ld=%b din=%h up=%b dw=%b want ld=%b din=%h up=0 dw=0",
                     e, LD, Din, Up, Dw, exp, dexp);
         end
      end
   endtask

   task automatic test_both_dirs;
      btnU = 1'b1;
      btnD = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e == 20) begin
            btnU = 1'b0;
            btnD = 1'b0;
         end
         checks++;
         if ({Up, Dw, LD} !== 3'b000) begin
            errors++;
            $display("FAIL both_dirs e=%0d got up=%b dw=%b ld=%b want 000",
                     e, Up, Dw, LD);
         end
      end
   endtask

   task automatic test_load_over_repeat;
      logic        eu, el;
      logic [15:0] dexp;
      sw   = 16'h0F0F;
      btnU = 1'b1;
      for (int e = 1; e <= 45; e++) begin
         @(posedge clk);
         #1;
         if (e == 14) btnL = 1'b1;
         if (e == 25) btnL = 1'b0;
         if (e == 28) btnU = 1'b0;
         el = (e == 21);
         eu = (e == 7) || (e >= 15 && e <= 33 && (e - 15) % 3 == 0 && e != 21);
         dexp = (e >= 21) ? 16'h0F0F : 16'hA5C3;
         checks++;
         if (Up !== eu || LD !== el || Dw !== 1'b0 || Din !== dexp) begin
            errors++;
            $display("FAIL load_over_repeat e=%0d got up=%b ld=%b dw=%b din=%h want up=%b ld=%b dw=0 din=%h",
                     e, Up, LD, Dw, Din, eu, el, dexp);
         end
      end
   endtask

   task automatic test_async_reset;
      btnU = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (Up !== 1'b1 || Din !== 16'h0F0F) begin
         errors++;
         $display("FAIL async_pre got up=%b din=%h want up=1 din=0f0f", Up, Din);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({Up, Dw, LD} !== 3'b000 || Din !== 16'h0000) begin
         errors++;
         $display("FAIL async_clear got %b%b%b din=%h want 000 din=0000",
                  Up, Dw, LD, Din);
      end
      btnU = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({Up, Dw, LD} !== 3'b000 || Din !== 16'h0000) begin
            errors++;
            $display("FAIL async_release e=%0d got %b%b%b din=%h want 000 din=0000",
                     e, Up, Dw, LD, Din);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      idle(10);
      test_bounce();
      idle(10);
      test_auto_repeat();
      idle(10);
      test_load();
      idle(10);
      test_both_dirs();
      idle(10);
      test_load_over_repeat();
      idle(10);
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
